regfile_2r1w_sb: RTL and testbench
==================================

# regfile_2r1w_sb

Two-read/one-write integer register file with a per-register busy scoreboard. It sits directly upstream of the ALU-operand 2:1 32-bit mux: `rd1`/`rd2` feed the mux data inputs, and the busy flags let the issue logic hold an instruction until its operands are valid. Register 0 is hardwired to zero. The file is cleared asynchronously on reset.

## Interface
- `DATA_W`, default 32: register and data width.
- `NREG`, default 32: number of registers; `AW = $clog2(NREG)` is derived, not overridable.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ra1` in AW: read address, port 1.
- `ra2` in AW: read address, port 2.
- `rd1` out DATA_W: read data, port 1 (combinational).
- `rd2` out DATA_W: read data, port 2 (combinational).
- `busy1` out 1: register `ra1` has a pending producer.
- `busy2` out 1: register `ra2` has a pending producer.
- `we` in 1: write enable.
- `wa` in AW: write address.
- `wd` in DATA_W: write data.
- `issue_valid` in 1: an instruction with a destination register issues this cycle.
- `issue_rd` in AW: destination register of the issuing instruction.
- `busy_cnt` out AW+1: number of registers currently marked busy (registered).

## Operation
- **Storage.** `regs[1..NREG-1]` and `busy[1..NREG-1]` are flops. Index 0 has no storage.
- **Reads.** Purely combinational.
  - `rdN = (raN==0) ? 0 : regs[raN]`.
  - `busyN = (raN==0) ? 0 : busy[raN]`.
- **Writes.** On a rising edge with `we=1` and `wa!=0`: `regs[wa] <= wd` and `busy[wa] <= 0`. A write to register 0 is ignored entirely.
- **Issue.** On a rising edge with `issue_valid=1` and `issue_rd!=0`: `busy[issue_rd] <= 1`. Issue to register 0 is ignored.
- **Simultaneous issue and write, same register.** Issue wins, so `busy` stays 1 (a new producer supersedes the old one). The data write still happens.
- **Issue to an already-busy register.** Legal (WAW). `busy` stays 1 and `busy_cnt` is unchanged.
- **Write to a non-busy register.** Legal; the data updates and `busy_cnt` is unchanged.
- **`busy_cnt`.** Equals the popcount of the `busy` vector after each edge, maintained incrementally:
  - +1 when an issue sets a previously clear bit;
  - −1 when a write clears a previously set bit;
  - no change when both apply to the same register, or when a set and a clear on different registers cancel.
  - Range is 0..NREG-1 and it never wraps.
- **Reset.** With `rst_n=0`, all `regs` = 0, all `busy` = 0 and `busy_cnt` = 0 immediately, independent of `clk`. Consequently `rd1`/`rd2` = 0 and `busy1`/`busy2` = 0 for any address. A reset mid-operation discards all pending state. The first edge after `rst_n` rises performs normal updates.

## Timing
- Read latency: 0 cycles (combinational from `raN` and current state).
- Write visibility: a write at edge N is visible on `rdN` after edge N; see Configuration for the same-cycle case.
- Scoreboard latency:
  - busy set at edge N is visible on `busyN` after edge N;
  - busy clear follows the same rule as write data.
- `busy_cnt` is registered and updates on the same edge as the bits it counts.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-to-read forwarding is enabled.
  - If `we=1`, `wa!=0` and `wa==raN`, then `rdN = wd` in the same cycle.
  - `busyN` is forced to 0 in the same cycle, unless `issue_valid=1` and `issue_rd==raN`, in which case `busyN` shows the stored `busy[raN]` value.
- `REGFILE_BYPASS_EN` undefined: no forwarding. `rdN` and `busyN` reflect stored state only, so a same-cycle read returns the old value and the old busy bit.
- Registered state behaves identically in both builds.

## Test plan
- **Reset.** Write `0xDEADBEEF` to r5, then assert `rst_n=0` mid-cycle → `rd1`(ra1=5) = 0 without a clock edge, and `busy_cnt` = 0.
- **Register 0.** Set `we=1`, `wa=0`, `wd=0xFFFFFFFF`, and issue `issue_rd=0` → `rd1`(ra1=0) = 0, `busy1` = 0, `busy_cnt` = 0.
- **Scoreboard round trip.**
  - Issue r7 → after the edge, `busy1`(ra1=7) = 1 and `busy_cnt` = 1.
  - Write r7 = `0x12345678` → after the edge, `rd1` = `0x12345678`, `busy1` = 0, `busy_cnt` = 0.
- **Collision.** With r3 busy, apply `issue_rd=3` and `we=1`, `wa=3`, `wd=0xA5A5A5A5` on the same edge → `rd2`(ra2=3) = `0xA5A5A5A5`, `busy2` = 1, `busy_cnt` unchanged.
- **Bypass.** With r9 = `0x1111`, apply `we=1`, `wa=9`, `wd=0x2222`, `ra1=9` before the edge:
  - `REGFILE_BYPASS_EN` defined → `rd1` = `0x2222`;
  - `REGFILE_BYPASS_EN` undefined → `rd1` = `0x1111`.
- **Random.** 1000 cycles of random `we`/`wa`/`wd`/`issue`/`ra` with occasional resets, checked every cycle against a reference model: `rd1`, `rd2`, `busy1`, `busy2` and `busy_cnt` all match, and `busy_cnt` ≤ 31.

Source files
------------

// File: rtl/regfile_2r1w_sb.sv
// Two-read/one-write register file with a per-register busy scoreboard and busy counter.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_2r1w_sb #(
    parameter  int DATA_W = 32,
    parameter  int NREG   = 32,
    localparam int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    output logic [AW:0]       busy_cnt
);

    // Register 0 has no storage; arrays start at index 1.
    logic [DATA_W-1:0] regs_q [1:NREG-1];
    logic [DATA_W-1:0] regs_d [1:NREG-1];
    logic [NREG-1:1]   busy_q;
    logic [NREG-1:1]   busy_d;
    logic [AW:0]       cnt_q;
    logic [AW:0]       cnt_d;

    logic wr_en;
    logic set_en;
    logic inc;
    logic dec;

    assign wr_en  = we && (wa != '0);
    assign set_en = issue_valid && (issue_rd != '0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        regs_d = regs_q;
        busy_d = busy_q;
        inc    = 1'b0;
        dec    = 1'b0;

        if (wr_en) begin
            regs_d[wa] = wd;
            busy_d[wa] = 1'b0;
        end
        // Issue is applied after the write so a new producer wins over a completing one.
        if (set_en) begin
            busy_d[issue_rd] = 1'b1;
        end

        if (set_en) begin
            inc = !busy_q[issue_rd];
        end
        if (wr_en) begin
            dec = busy_q[wa] && !(set_en && (issue_rd == wa));
        end
        cnt_d = cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the whole array is reset here; this is legal only because it is built from flops, not a RAM macro.
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    always_comb begin
        rd1   = (ra1 == '0) ? '0   : regs_q[ra1];
        rd2   = (ra2 == '0) ? '0   : regs_q[ra2];
        busy1 = (ra1 == '0) ? 1'b0 : busy_q[ra1];
        busy2 = (ra2 == '0) ? 1'b0 : busy_q[ra2];
`ifdef REGFILE_BYPASS_EN
        // A same-cycle write forwards its data and retires the busy bit, unless a new producer also issues.
        if (wr_en && (wa == ra1)) begin
            rd1   = wd;
            busy1 = (issue_valid && (issue_rd == ra1)) ? busy_q[ra1] : 1'b0;
        end
        if (wr_en && (wa == ra2)) begin
            rd2   = wd;
            busy2 = (issue_valid && (issue_rd == ra2)) ? busy_q[ra2] : 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Self-checking bench for regfile_2r1w_sb: directed cases plus a randomized run against a
// reference model, with expected outputs queued on drive and compared on sample.
module tb_regfile_2r1w_sb;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ra1, ra2, wa, issue_rd;
    logic [DW-1:0] rd1, rd2, wd;
    logic          busy1, busy2, we, issue_valid;
    logic [AW:0]   busy_cnt;

    regfile_2r1w_sb #(.DATA_W(DW), .NREG(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2),
        .we(we), .wa(wa), .wd(wd),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic          b1;
        logic          b2;
        logic [AW:0]   cnt;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_regs [NR];
    logic          m_busy [NR];
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic int m_popcount();
        int c = 0;
        for (int i = 1; i < NR; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Expected combinational outputs for the currently driven inputs and model state.
    function automatic exp_t model_out();
        exp_t e;
        e.rd1 = (ra1 == 0) ? '0 : m_regs[ra1];
        e.rd2 = (ra2 == 0) ? '0 : m_regs[ra2];
        e.b1  = (ra1 == 0) ? 1'b0 : m_busy[ra1];
        e.b2  = (ra2 == 0) ? 1'b0 : m_busy[ra2];
`ifdef REGFILE_BYPASS_EN
        if (we && wa != 0 && wa == ra1) begin
            e.rd1 = wd;
            if (!(issue_valid && issue_rd == ra1)) e.b1 = 1'b0;
        end
        if (we && wa != 0 && wa == ra2) begin
            e.rd2 = wd;
            if (!(issue_valid && issue_rd == ra2)) e.b2 = 1'b0;
        end
`endif
        e.cnt = (AW+1)'(m_popcount());
        return e;
    endfunction

    task automatic model_edge();
        if (rst_n) begin
            if (we && wa != 0) begin
                m_regs[wa] = wd;
                m_busy[wa] = 1'b0;
            end
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
    endtask

    task automatic push_exp();
        exp_q.push_back(model_out());
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_rd1"},   rd1,   e.rd1);
        check({tag, "_rd2"},   rd2,   e.rd2);
        check({tag, "_busy1"}, DW'(busy1), DW'(e.b1));
        check({tag, "_busy2"}, DW'(busy2), DW'(e.b2));
        check({tag, "_cnt"},   DW'(busy_cnt), DW'(e.cnt));
    endtask

    // Called at posedge+1 with inputs already driven: check pre-edge outputs, then clock.
    task automatic step(input string tag);
        push_exp();
        @(negedge clk);
        pop_check(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we = 1'b0; issue_valid = 1'b0; wa = '0; wd = '0; issue_rd = '0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ra1 = 5; ra2 = 0; we = 0; wa = 0; wd = 0; issue_valid = 0; issue_rd = 0;
        model_reset();
        #3;
        check("reset_rd1", rd1, 0);
        check("reset_cnt", DW'(busy_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        #1;

        // Asynchronous reset mid-cycle after writing r5 and issuing r6.
        we = 1; wa = 5; wd = 32'hDEADBEEF; issue_valid = 1; issue_rd = 6; ra1 = 5; ra2 = 6;
        step("wr_r5");
        idle();
        check("r5_written", rd1, 32'hDEADBEEF);
        check("r6_busy_cnt", DW'(busy_cnt), 1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_rd1", rd1, 0);
        check("async_rst_busy2", DW'(busy2), 0);
        check("async_rst_cnt", DW'(busy_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        #1;

        // Register 0 ignores writes and issues.
        we = 1; wa = 0; wd = 32'hFFFFFFFF; issue_valid = 1; issue_rd = 0; ra1 = 0; ra2 = 0;
        step("r0");
        idle();
        check("r0_rd1", rd1, 0);
        check("r0_busy1", DW'(busy1), 0);
        check("r0_cnt", DW'(busy_cnt), 0);

        // Scoreboard round trip on r7.
        issue_valid = 1; issue_rd = 7; ra1 = 7;
        step("issue_r7");
        idle();
        check("r7_busy1", DW'(busy1), 1);
        check("r7_cnt1", DW'(busy_cnt), 1);
        we = 1; wa = 7; wd = 32'h12345678;
        step("write_r7");
        idle();
        check("r7_rd1", rd1, 32'h12345678);
        check("r7_busy1_clr", DW'(busy1), 0);
        check("r7_cnt0", DW'(busy_cnt), 0);

        // Issue and write collide on busy r3.
        issue_valid = 1; issue_rd = 3; ra2 = 3;
        step("issue_r3");
        idle();
        we = 1; wa = 3; wd = 32'hA5A5A5A5; issue_valid = 1; issue_rd = 3; ra2 = 3;
        step("collide_r3");
        idle();
        check("col_rd2", rd2, 32'hA5A5A5A5);
        check("col_busy2", DW'(busy2), 1);
        check("col_cnt", DW'(busy_cnt), 1);

        // Same-cycle read of a register being written.
        we = 1; wa = 9; wd = 32'h1111; ra1 = 9;
        step("wr_r9");
        idle();
        we = 1; wa = 9; wd = 32'h2222; ra1 = 9;
        #2;
`ifdef REGFILE_BYPASS_EN
        check("bypass_rd1", rd1, 32'h2222);
`else
        check("bypass_rd1", rd1, 32'h1111);
`endif
        step("wr_r9b");
        idle();

        // Randomized traffic with occasional mid-cycle resets.
        for (int cyc = 0; cyc < 1000; cyc++) begin
            we          = 1'($urandom_range(0, 1));
            issue_valid = 1'($urandom_range(0, 1));
            wa          = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            issue_rd    = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wd          = $urandom;
            ra1         = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            ra2         = ($urandom_range(0, 3) == 0) ? issue_rd : AW'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                push_exp();
                pop_check("rnd_rst");
                rst_n = 1'b1;
            end
            step("rnd");
            check("rnd_cnt_range", DW'(busy_cnt <= 31), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
